acia_rx_framer: RTL and testbench
=================================

// Module: acia_rx_framer
// PURPOSE
//  Serial receive framer fed by the serial ULA's RxC/RxD/DCD outputs (cassette or RS423 path).
//  Oversamples RxD on rising edges of RxC, detects start bit, shifts 8 data bits LSB first,
//  optional parity, checks stop bit; presents byte + status to the host-side register block.
//  Replaces the receive half of the 6850 for FPGA builds; runs entirely in the fast clk domain.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (fixed 8 in this build, kept for width sizing)
//  SYNC_STAGES 2   flops in RxC/RxD/DCD input synchronisers (>=2)
// PORTS
//  clk        in   1  fast system clock (16/13 MHz domain as ULA)
//  rst        in   1  asynchronous active-high reset
//  rxc        in   1  receive clock from ULA (async to clk, pulse/burst shaped)
//  rxd        in   1  receive data from ULA
//  dcd        in   1  carrier/high-tone detect from ULA, active high
//  divsel     in   2  RxC divide: 00=/1, 01=/16, 10=/64, 11=reset-hold (framer idle)
//  par_en     in   1  1 = parity bit follows data
//  par_odd    in   1  1 = odd parity, 0 = even
//  rd_ack     in   1  1-cycle pulse: host has read rx_data; clears rdrf/ovr/fe/pe/dcd_evt
//  rx_data    out  8  last accepted byte
//  rdrf       out  1  receive data register full
//  ovr        out  1  overrun: frame completed while rdrf=1
//  fe         out  1  framing error (stop bit sampled 0) for byte in rx_data
//  pe         out  1  parity error for byte in rx_data
//  dcd_evt    out  1  latched rising edge of synchronised dcd
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, rx_data=8'h00, FSM=IDLE, tick counter=0, synchronisers cleared to 1 (rxd,rxc) / 0 (dcd).
//  Tick: rising edge of synchronised rxc, one clk-cycle pulse; latency rxc edge->tick = SYNC_STAGES+1 clk.
//  N = 1/16/64 per divsel, latched at start-bit detect; divsel changes mid-frame ignored until IDLE.
//  divsel=11: FSM forced to IDLE each cycle, status flags unaffected.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: armed only after rxd sampled 1 on >=1 tick (break/low line does not retrigger);
//         on tick with rxd=0 -> START, cnt=0.
//   START: N=1 -> go DATA immediately (start bit already sampled).
//          N>1 -> on tick count to N/2-1; at mid-bit rxd=1 -> false start, IDLE; else DATA, cnt=0.
//   DATA: sample rxd every N ticks (mid-bit), shift right into sreg[7]; after 8 samples ->
//         PARITY if par_en else STOP.
//   PARITY: one sample; perr = (^sreg ^ sample) != par_odd.
//   STOP: one sample; frame complete in the same cycle as that tick -> IDLE.
//  Completion (one cycle): if rdrf=0 or rd_ack same cycle: rx_data<=sreg, rdrf<=1, fe<=!stop,
//   pe<=perr&par_en; else ovr<=1, rx_data/fe/pe retained (new byte dropped).
//  rd_ack alone: rdrf, ovr, fe, pe, dcd_evt <= 0. rd_ack with completion: new byte wins (flags set).
//  dcd_evt set on sync dcd 0->1; set beats rd_ack if same cycle.
//  Counter widths: cnt 6 bits, bit index 3 bits; no wrap past N-1 (reset to 0 on each sample).
//  Reset mid-frame: asynchronous abort, partial byte discarded, no flags set.
// STRUCTURE
//  Shared package serial_pkg: DIV_1/DIV_16/DIV_64/DIV_HOLD encodings, rx FSM state enum
//   (RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP), div_ratio() lookup.
//  One sub-module: sync_edge (SYNC_STAGES synchroniser + rising-edge pulse), instanced for rxc and dcd;
//   rxd uses synchroniser only. Framer FSM, shift register and status flags in the top module.
// TESTING
//  1. divsel=00, par_en=0, rxc 1200Hz clock, send 0x55 8N1 -> rdrf=1, rx_data=0x55, fe=pe=ovr=0 after stop tick.
//  2. divsel=01, send 0xA3 with even parity (p=0) -> rx_data=0xA3, pe=0; repeat p=1 -> pe=1, rdrf=1.
//  3. divsel=10, rxd low for 20 ticks then high -> false start, busy returns 0, rdrf stays 0.
//  4. Two bytes 0x12,0x34 with no rd_ack -> rx_data=0x12, ovr=1; rd_ack -> all flags 0;
//     rd_ack coincident with 2nd completion -> rx_data=0x34, ovr=0.
//  5. Stop bit forced 0 on 0xFF, then line held low 30 ticks -> fe=1, rx_data=0xFF, no new frame until rxd=1.
//  6. rst asserted mid-DATA of 0x7E, released -> outputs all 0, next full frame 0x7E received correctly;
//     dcd pulse 0->1 -> dcd_evt=1 until rd_ack.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared encodings for the serial receive path: RxC divide selection,
// receive framer states and the divide-ratio lookup.
package serial_pkg;

    typedef enum logic [1:0] {
        DIV_1    = 2'b00,
        DIV_16   = 2'b01,
        DIV_64   = 2'b10,
        DIV_HOLD = 2'b11
    } div_sel_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned BIT_W = 3;

    function automatic logic [6:0] div_ratio(input div_sel_e sel);
        logic [6:0] r;
        case (sel)
            DIV_1:   r = 7'd1;
            DIV_16:  r = 7'd16;
            DIV_64:  r = 7'd64;
            default: r = 7'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, producing a single
// clk-cycle pulse on each rising edge of the synchronised signal.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // prev_q resets to the same level as the chain so reset release cannot fake an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/acia_rx_framer.sv
// Receive framer: oversamples RxD on synchronised RxC ticks, assembles
// 8-bit frames with optional parity and presents byte plus status flags.
module acia_rx_framer
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxc,
    input  logic                 rxd,
    input  logic                 dcd,
    input  logic [1:0]           divsel,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdrf,
    output logic                 ovr,
    output logic                 fe,
    output logic                 pe,
    output logic                 dcd_evt,
    output logic                 busy
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                   tick;
    logic                   dcd_rise;
    logic [SYNC_STAGES-1:0] rxd_sync_q;
    logic                   rxd_s;

    rx_state_e              state_q, state_d;
    div_sel_e               div_q, div_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   sreg_q, sreg_d;
    logic                   perr_q, perr_d;
    logic                   armed_q, armed_d;

    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rdrf_q, rdrf_d;
    logic                   ovr_q, ovr_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   dcd_evt_q, dcd_evt_d;

    logic [6:0]             ratio;
    logic [CNT_W-1:0]       cnt_last;
    logic [CNT_W-1:0]       half_last;
    logic                   sample;
    logic                   complete;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rxc_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (rxc),
        .rise (tick)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_dcd_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (dcd),
        .rise (dcd_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_sync_q <= '1;
        end else begin
            rxd_sync_q <= {rxd_sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s     = rxd_sync_q[SYNC_STAGES-1];
    assign ratio     = div_ratio(div_q);
    assign cnt_last  = CNT_W'(ratio - 7'd1);
    assign half_last = CNT_W'((ratio >> 1) - 7'd1);
    assign sample    = tick && (cnt_q == cnt_last);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        perr_d   = perr_q;
        armed_d  = armed_q;
        complete = 1'b0;

        if (div_sel_e'(divsel) == DIV_HOLD) begin
            state_d = RX_IDLE;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    // A low line only starts a frame once a high sample has been seen
                    if (tick) begin
                        if (rxd_s) begin
                            armed_d = 1'b1;
                        end else if (armed_q) begin
                            state_d = RX_START;
                            div_d   = div_sel_e'(divsel);
                            cnt_d   = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            armed_d = 1'b0;
                        end
                    end
                end
                RX_START: begin
                    if (div_q == DIV_1) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == half_last) begin
                            cnt_d = '0;
                            if (rxd_s) begin
                                state_d = RX_IDLE;
                                armed_d = 1'b1;
                            end else begin
                                state_d = RX_DATA;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (sample) begin
                        cnt_d  = '0;
                        sreg_d = {rxd_s, sreg_q[DATA_BITS-1:1]};
                        bit_d  = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_d = par_en ? RX_PARITY : RX_STOP;
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (sample) begin
                        cnt_d   = '0;
                        perr_d  = ((^sreg_q) ^ rxd_s) != par_odd;
                        state_d = RX_STOP;
                    end else if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (sample) begin
                        cnt_d    = '0;
                        complete = 1'b1;
                        armed_d  = rxd_s;
                        state_d  = RX_IDLE;
                    end else if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        data_d    = data_q;
        rdrf_d    = rdrf_q;
        ovr_d     = ovr_q;
        fe_d      = fe_q;
        pe_d      = pe_q;
        dcd_evt_d = dcd_evt_q;

        // A read in the completion cycle frees the register, so the new byte is accepted
        if (complete) begin
            if (!rdrf_q || rd_ack) begin
                data_d = sreg_q;
                rdrf_d = 1'b1;
                ovr_d  = 1'b0;
                fe_d   = ~rxd_s;
                pe_d   = perr_q & par_en;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_ack) begin
            rdrf_d = 1'b0;
            ovr_d  = 1'b0;
            fe_d   = 1'b0;
            pe_d   = 1'b0;
        end

        if (dcd_rise) begin
            dcd_evt_d = 1'b1;
        end else if (rd_ack) begin
            dcd_evt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            div_q     <= DIV_1;
            cnt_q     <= '0;
            bit_q     <= '0;
            sreg_q    <= '0;
            perr_q    <= 1'b0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            rdrf_q    <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            dcd_evt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            perr_q    <= perr_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            rdrf_q    <= rdrf_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            dcd_evt_q <= dcd_evt_d;
        end
    end

    assign rx_data = data_q;
    assign rdrf    = rdrf_q;
    assign ovr     = ovr_q;
    assign fe      = fe_q;
    assign pe      = pe_q;
    assign dcd_evt = dcd_evt_q;
    assign busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_acia_rx_framer.sv
// Directed plus randomized frames for acia_rx_framer, checked against a
// frame-level model of the host-visible byte and status flags.
module tb_acia_rx_framer;

    logic       clk;
    logic       rst;
    logic       rxc;
    logic       rxd;
    logic       dcd;
    logic [1:0] divsel;
    logic       par_en;
    logic       par_odd;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rdrf;
    logic       ovr;
    logic       fe;
    logic       pe;
    logic       dcd_evt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Host-visible state expected after each transaction
    logic [7:0] m_data;
    logic       m_rdrf;
    logic       m_ovr;
    logic       m_fe;
    logic       m_pe;
    logic       m_dcd;

    acia_rx_framer #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxc     (rxc),
        .rxd     (rxd),
        .dcd     (dcd),
        .divsel  (divsel),
        .par_en  (par_en),
        .par_odd (par_odd),
        .rd_ack  (rd_ack),
        .rx_data (rx_data),
        .rdrf    (rdrf),
        .ovr     (ovr),
        .fe      (fe),
        .pe      (pe),
        .dcd_evt (dcd_evt),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int n_of(input logic [1:0] sel);
        return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 16 : 64;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        @(negedge clk);
        check($sformatf("%s/rx_data", tag), rx_data, m_data);
        check($sformatf("%s/rdrf", tag), {7'd0, rdrf}, {7'd0, m_rdrf});
        check($sformatf("%s/ovr", tag), {7'd0, ovr}, {7'd0, m_ovr});
        check($sformatf("%s/fe", tag), {7'd0, fe}, {7'd0, m_fe});
        check($sformatf("%s/pe", tag), {7'd0, pe}, {7'd0, m_pe});
        check($sformatf("%s/dcd_evt", tag), {7'd0, dcd_evt}, {7'd0, m_dcd});
        check($sformatf("%s/busy", tag), {7'd0, busy}, {7'd0, exp_busy});
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rdrf = 0; m_ovr = 0; m_fe = 0; m_pe = 0; m_dcd = 0;
    endtask

    task automatic model_ack();
        m_rdrf = 0; m_ovr = 0; m_fe = 0; m_pe = 0; m_dcd = 0;
    endtask

    task automatic model_frame(input logic [7:0] data, input logic pen, input logic podd,
                               input logic pbit, input logic stopb, input logic ack);
        if (!m_rdrf || ack) begin
            m_data = data;
            m_rdrf = 1;
            m_ovr  = 0;
            m_fe   = !stopb;
            m_pe   = pen && ((($countones(data) + int'(pbit)) % 2) != int'(podd));
        end else begin
            m_ovr = 1;
        end
        if (ack) m_dcd = 0;
    endtask

    // One RxC period: low half carries the new RxD level, rising edge in the middle.
    // With ack set, rd_ack lands in the cycle the framer acts on this edge.
    task automatic rxc_cycle(input logic bitval, input logic ack);
        rxd = bitval;
        rxc = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxc = 1'b1;
        if (ack) begin
            repeat (3) @(posedge clk);
            #1 rd_ack = 1'b1;
            @(posedge clk);
            #1 rd_ack = 1'b0;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic bitval, input int n, input int ack_tick);
        for (int k = 1; k <= n; k++) rxc_cycle(bitval, ack_tick == k);
    endtask

    task automatic do_ack();
        rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
        model_ack();
    endtask

    task automatic dcd_pulse();
        dcd = 1'b1;
        repeat (6) @(posedge clk);
        #1 dcd = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        m_dcd = 1;
    endtask

    // Stop bit is sampled on tick N/2+1 of its bit time (tick 1 when N=1)
    task automatic send_frame(input logic [7:0] data, input int n, input logic pbit,
                              input logic stopb, input logic ack, input logic scramble);
        send_bit(1'b1, n + 1, 0);
        send_bit(1'b0, n, 0);
        if (scramble) divsel = 2'($urandom_range(0, 2));
        for (int i = 0; i < 8; i++) send_bit(data[i], n, 0);
        if (par_en) send_bit(pbit, n, 0);
        send_bit(stopb, n, ack ? (n / 2 + 1) : 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] data, input logic pbit, input logic stopb,
                            input logic ack, input logic scramble);
        logic [1:0] sel;
        logic       pen;
        logic       podd;
        sel  = divsel;
        pen  = par_en;
        podd = par_odd;
        send_frame(data, n_of(sel), pbit, stopb, ack, scramble);
        divsel = sel;
        model_frame(data, pen, podd, pbit, stopb, ack);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] part;
        logic       pb;
        rst = 1; rxc = 0; rxd = 1; dcd = 0; divsel = 2'b00;
        par_en = 0; par_odd = 0; rd_ack = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // /1, 8N1
        divsel = 2'b00;
        rx_frame(8'h55, 0, 1, 0, 0);
        check_all("div1_55", 0);

        // Hold mode keeps the framer idle and leaves flags alone
        divsel = 2'b11;
        send_frame(8'h99, 16, 0, 1, 0, 0);
        check_all("hold", 0);

        // /16 even parity, correct then wrong parity bit
        do_ack();
        divsel = 2'b01; par_en = 1; par_odd = 0;
        rx_frame(8'hA3, 0, 1, 0, 0);
        check_all("par_ok", 0);
        do_ack();
        rx_frame(8'hA3, 1, 1, 0, 0);
        check_all("par_bad", 0);
        par_en = 0;

        // /64 false start: 20 low ticks then high
        do_ack();
        divsel = 2'b10;
        send_bit(1'b1, 65, 0);
        send_bit(1'b0, 10, 0);
        check_all("fstart_mid", 1);
        send_bit(1'b0, 10, 0);
        send_bit(1'b1, 64, 0);
        check_all("fstart_end", 0);

        // Overrun, then read clears, then read coincident with completion
        divsel = 2'b01;
        rx_frame(8'h12, 0, 1, 0, 0);
        rx_frame(8'h34, 0, 1, 0, 0);
        check_all("ovr_set", 0);
        do_ack();
        check_all("ovr_ack", 0);
        rx_frame(8'h12, 0, 1, 0, 0);
        rx_frame(8'h34, 0, 1, 1, 0);
        check_all("ack_coinc", 0);

        // Framing error then a low line must not retrigger
        do_ack();
        rx_frame(8'hFF, 0, 0, 0, 0);
        check_all("fe", 0);
        send_bit(1'b0, 15, 0);
        check_all("break_mid", 0);
        send_bit(1'b0, 15, 0);
        check_all("break_end", 0);

        // Reset mid-DATA of 0x7E, then the full frame
        dcd_pulse();
        check_all("dcd_pre", 0);
        part = 8'h7E;
        send_bit(1'b1, 17, 0);
        send_bit(1'b0, 16, 0);
        for (int i = 0; i < 3; i++) send_bit(part[i], 16, 0);
        send_bit(part[3], 5, 0);
        rst = 1;
        model_reset();
        check_all("rst_mid", 0);
        rxd = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rx_frame(8'h7E, 0, 1, 0, 0);
        check_all("after_rst", 0);
        dcd_pulse();
        check_all("dcd_set", 0);
        do_ack();
        check_all("dcd_ack", 0);

        // Randomized frames
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            if ($urandom_range(0, 3) == 0) dcd_pulse();
            divsel  = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            d       = 8'($urandom_range(0, 255));
            pb      = (par_odd ? ~(^d) : (^d)) ^ ($urandom_range(0, 3) == 0);
            rx_frame(d, pb, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0);
            check_all($sformatf("rand%0d", t), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
